// File: rtl/vector_operand_loader_11.sv
// -----------------------------------------------------------------------------
// vector_operand_loader_11
//
// Producer-side front end for the 11-element registered vector adder.
//
// A serial element stream arrives one element per transfer: A0..A10 first,
// then B0..B10. The loader assembles both operand vectors in parallel
// registers. It then raises outReady for one cycle to launch the adder.
// After that it refuses further elements until the adder reports its
// result (resultReady), so only one vector operation is ever in flight.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   enable       global clock enable; low freezes every register
//   inValid      serial element valid
//   inData       serial element (signed, stored bit-exact)
//   inAccept     loader can take an element this cycle (combinational)
//   Avec, Bvec   assembled operands; element i at [i*IN_WIDTH +: IN_WIDTH]
//   outReady     one-cycle launch strobe to the adder's inReady
//   resultReady  adder's outReady (vector sum valid)
//   busy         high whenever the loader is not in LOAD
//   protoErr     sticky flag: resultReady seen while nothing was in flight
// -----------------------------------------------------------------------------
module vector_operand_loader_11 #(
  parameter int IN_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     inValid,
  input  logic [IN_WIDTH-1:0]      inData,
  output logic                     inAccept,
  output logic [11*IN_WIDTH-1:0]   Avec,
  output logic [11*IN_WIDTH-1:0]   Bvec,
  output logic                     outReady,
  input  logic                     resultReady,
  output logic                     busy,
  output logic                     protoErr
);

  localparam int          NUM_ELEM   = 11;
  localparam logic [4:0]  B_BASE     = 5'd11;  // first B element index
  localparam logic [4:0]  LAST_COUNT = 5'd21;  // index of the 22nd transfer

  typedef enum logic [1:0] {
    LOAD  = 2'd0,  // collecting elements
    ISSUE = 2'd1,  // vectors complete, strobe the adder
    WAIT  = 2'd2   // operation in flight, waiting for the sum
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [4:0]  count;
  logic [4:0]  count_nxt;
  logic        outready_nxt;
  logic        proto_nxt;

  logic        xfer;
  logic        a_we;
  logic        b_we;
  logic [4:0]  b_off;
  logic [3:0]  a_idx;
  logic [3:0]  b_idx;

  // ---------------------------------------------------------------------------
  // Handshake. inAccept deliberately ignores inValid so that the source can
  // make its decision without a combinational loop through this block.
  // Reset gates it combinationally, so no element is accepted in a reset cycle.
  // ---------------------------------------------------------------------------
  assign inAccept = (state == LOAD) && enable && !reset;
  assign xfer     = inValid && inAccept;
  assign busy     = (state != LOAD);

  // Element address decode: counts 0..10 go to A, 11..21 go to B.
  assign b_off = count - B_BASE;
  assign a_idx = count[3:0];
  assign b_idx = b_off[3:0];
  assign a_we  = xfer && (count <  B_BASE);
  assign b_we  = xfer && (count >= B_BASE);

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_nxt = state;
    count_nxt = count;

    case (state)
      LOAD: begin
        if (xfer) begin
          if (count == LAST_COUNT) begin
            count_nxt = '0;
            state_nxt = ISSUE;
          end else begin
            count_nxt = count + 5'd1;
          end
        end
      end
      ISSUE: begin
        state_nxt = WAIT;
      end
      WAIT: begin
        if (resultReady) begin
          state_nxt = LOAD;
        end
      end
      default: begin
        // Unused encoding: recover to a clean load.
        state_nxt = LOAD;
        count_nxt = '0;
      end
    endcase

    // The strobe is registered, so it is high exactly while the FSM sits in
    // ISSUE, which is the cycle after the 22nd transfer.
    outready_nxt = (state_nxt == ISSUE);

    // A result with nothing in flight is a protocol violation. The flag is
    // sticky until reset.
    proto_nxt = protoErr ||
                (resultReady && ((state == LOAD) || (state == ISSUE)));
  end

  // ---------------------------------------------------------------------------
  // State and storage registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= LOAD;
      count    <= '0;
      outReady <= 1'b0;
      protoErr <= 1'b0;
      // NOTE: the operand registers are cleared on reset so that a partial
      // vector left over from an aborted load can never reach the adder.
      Avec     <= '0;
      Bvec     <= '0;
    end else if (enable) begin
      // NOTE: non-blocking assignments throughout, so that every register
      // samples the pre-edge values of the others.
      state    <= state_nxt;
      count    <= count_nxt;
      outReady <= outready_nxt;
      protoErr <= proto_nxt;
      for (int i = 0; i < NUM_ELEM; i++) begin
        if (a_we && (a_idx == 4'(i))) begin
          Avec[i*IN_WIDTH +: IN_WIDTH] <= inData;
        end
        if (b_we && (b_idx == 4'(i))) begin
          Bvec[i*IN_WIDTH +: IN_WIDTH] <= inData;
        end
      end
    end
  end

endmodule

// File: tb/tb_vector_operand_loader_11.sv
// -----------------------------------------------------------------------------
// tb_vector_operand_loader_11
//
// Directed self-checking bench for vector_operand_loader_11 (IN_WIDTH = 10).
// Inputs are driven 1 ns after a rising edge. Outputs are sampled at the same
// point, well away from the next active edge.
// -----------------------------------------------------------------------------
module tb_vector_operand_loader_11;

  localparam int W = 10;

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic            inValid;
  logic [W-1:0]    inData;
  logic            inAccept;
  logic [11*W-1:0] Avec;
  logic [11*W-1:0] Bvec;
  logic            outReady;
  logic            resultReady;
  logic            busy;
  logic            protoErr;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0]    stim [22];
  logic [11*W-1:0] exp_a;
  logic [11*W-1:0] exp_b;

  vector_operand_loader_11 #(.IN_WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .inValid     (inValid),
    .inData      (inData),
    .inAccept    (inAccept),
    .Avec        (Avec),
    .Bvec        (Bvec),
    .outReady    (outReady),
    .resultReady (resultReady),
    .busy        (busy),
    .protoErr    (protoErr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected operand vectors from the current stimulus table.
  task automatic build_expect();
    for (int i = 0; i < 11; i++) begin
      exp_a[i*W +: W] = stim[i];
      exp_b[i*W +: W] = stim[11+i];
    end
  endtask

  // Streams stim[start..stop-1]. toggle alternates inValid 1/0. When the
  // transfer count reaches stall_at, enable is dropped for 5 cycles while
  // inValid stays high. Returns just after the edge of the last transfer.
  task automatic run_stream(input string tag, input int start, input int stop,
                            input bit toggle, input int stall_at);
    int  n      = start;
    int  cyc    = 0;
    int  early  = 0;
    bit  phase  = 1'b1;
    bit  take;
    bit  stalled = 1'b0;
    check({tag, "_accept_start"}, 128'(inAccept), 128'(1));
    while (n < stop && cyc < 300) begin
      if (n == stall_at && !stalled) begin
        stalled = 1'b1;
        enable  = 1'b0;
        inValid = 1'b1;
        inData  = stim[n];
        #1;
        check({tag, "_accept_stall"}, 128'(inAccept), 128'(0));
        repeat (5) begin
          tick();
          cyc++;
          if (outReady) early++;
        end
        enable = 1'b1;
      end
      inValid = toggle ? phase : 1'b1;
      inData  = inValid ? stim[n] : 10'h3AA;
      phase   = ~phase;
      take    = inValid;
      tick();
      cyc++;
      if (take) n++;
      if (n < 22 && outReady) early++;
    end
    inValid = 1'b0;
    inData  = '0;
    check({tag, "_done"}, 128'(n), 128'(stop));
    check({tag, "_no_early_ready"}, 128'(early), 128'(0));
  endtask

  // Call right after the 22nd transfer: ISSUE then WAIT, with vectors intact.
  task automatic check_issue(input string tag);
    build_expect();
    check({tag, "_outReady_hi"}, 128'(outReady), 128'(1));
    check({tag, "_busy_issue"},  128'(busy),     128'(1));
    check({tag, "_accept_issue"},128'(inAccept), 128'(0));
    check({tag, "_Avec"},        128'(Avec),     128'(exp_a));
    check({tag, "_Bvec"},        128'(Bvec),     128'(exp_b));
    tick();
    check({tag, "_outReady_lo"}, 128'(outReady), 128'(0));
    check({tag, "_busy_wait"},   128'(busy),     128'(1));
  endtask

  task automatic release_wait(input string tag);
    resultReady = 1'b1;
    tick();
    resultReady = 1'b0;
    check({tag, "_busy_load"},   128'(busy),     128'(0));
    check({tag, "_accept_load"}, 128'(inAccept), 128'(1));
  endtask

  task automatic reset_checks(input string tag);
    reset = 1'b1;
    #1;
    check({tag, "_accept_in_reset"}, 128'(inAccept), 128'(0));
    tick();
    check({tag, "_Avec"},     128'(Avec),     128'(0));
    check({tag, "_Bvec"},     128'(Bvec),     128'(0));
    check({tag, "_outReady"}, 128'(outReady), 128'(0));
    check({tag, "_protoErr"}, 128'(protoErr), 128'(0));
    check({tag, "_busy"},     128'(busy),     128'(0));
    reset = 1'b0;
    #1;
    check({tag, "_accept_after"}, 128'(inAccept), 128'(1));
  endtask

  initial begin
    reset       = 1'b1;
    enable      = 1'b1;
    inValid     = 1'b0;
    inData      = '0;
    resultReady = 1'b0;
    tick();

    // 1. Reset state.
    reset_checks("rst");

    // 2. Back-to-back stream 1..22.
    for (int i = 0; i < 22; i++) stim[i] = 10'(i + 1);
    run_stream("seq", 0, 22, 1'b0, -1);
    check_issue("seq");

    // WAIT: 10 cycles of inValid with a value that must never be taken.
    inValid = 1'b1;
    inData  = 10'h155;
    for (int c = 0; c < 10; c++) begin
      check("wait_accept", 128'(inAccept), 128'(0));
      tick();
    end
    inValid = 1'b0;
    check("wait_Avec_hold", 128'(Avec), 128'(exp_a));
    check("wait_Bvec_hold", 128'(Bvec), 128'(exp_b));
    release_wait("seq_rel");
    check("seq_rel_protoErr", 128'(protoErr), 128'(0));

    // 3. Negative/positive extremes: A = -512, B = 511. The first element
    // lands in A0 straight after the WAIT release.
    for (int i = 0; i < 11; i++) stim[i] = 10'h200;
    for (int i = 11; i < 22; i++) stim[i] = 10'h1FF;
    inValid = 1'b1;
    inData  = stim[0];
    tick();
    inValid = 1'b0;
    exp_a = {10'd11, 10'd10, 10'd9, 10'd8, 10'd7, 10'd6,
             10'd5, 10'd4, 10'd3, 10'd2, 10'h200};
    check("neg_A0_lands", 128'(Avec), 128'(exp_a));

    // Spurious resultReady at count=3 sets the sticky error.
    run_stream("neg_a", 1, 3, 1'b0, -1);
    resultReady = 1'b1;
    tick();
    resultReady = 1'b0;
    check("proto_set", 128'(protoErr), 128'(1));
    run_stream("neg_b", 3, 22, 1'b0, -1);
    check_issue("neg");
    check("neg_elem_A5", 128'(Avec[5*W +: W]), 128'(10'h200));
    check("neg_elem_B9", 128'(Bvec[9*W +: W]), 128'(10'h1FF));
    release_wait("neg_rel");
    check("proto_sticky1", 128'(protoErr), 128'(1));

    // 4. inValid toggling every cycle.
    for (int i = 0; i < 22; i++) stim[i] = 10'(100 + 3 * i);
    run_stream("tog", 0, 22, 1'b1, -1);
    check_issue("tog");
    release_wait("tog_rel");
    check("proto_sticky2", 128'(protoErr), 128'(1));

    // 5. enable low for 5 cycles at count=7, including negative elements.
    for (int i = 0; i < 22; i++) stim[i] = 10'(i * 37 - 300);
    run_stream("stall", 0, 22, 1'b0, 7);
    check_issue("stall");
    release_wait("stall_rel");

    // 6. Reset at count=15 discards the partial load; then a fresh stream.
    for (int i = 0; i < 22; i++) stim[i] = 10'(511 - 5 * i);
    run_stream("part", 0, 15, 1'b0, -1);
    reset_checks("midrst");
    run_stream("fresh", 0, 22, 1'b0, -1);
    check_issue("fresh");
    release_wait("fresh_rel");
    check("fresh_protoErr", 128'(protoErr), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
